alarm_scheduler: RTL and testbench

//  Alarm sequencer for the 24h clock datapath. It holds the alarm time loaded from the keyboard

---
 rtl/alarm_scheduler_if.sv | 34 +++
 rtl/alarm_scheduler.sv | 149 ++++++++++++++
 tb/tb_alarm_scheduler.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_scheduler_if.sv
// Alarm sequencer bus: time-of-day inputs, keyboard load/keys, and the ring/stored-alarm outputs.
interface alarm_scheduler_if;
    logic       sec_tick;
    logic [5:0] clock_hour;
    logic [5:0] clock_minute;
    logic [5:0] clock_second;
    logic       alarm_arm;
    logic       alarm_load;
    logic [5:0] alarm_h;
    logic [5:0] alarm_m;
    logic [5:0] alarm_s;
    logic       stop_key;
    logic       snooze_key;
    logic       ring;
    logic       ring_blink;
    logic       snoozing;
    logic       load_err;
    logic [5:0] alarm_hour_q;
    logic [5:0] alarm_minute_q;
    logic [5:0] alarm_second_q;

    modport master (
        output sec_tick, clock_hour, clock_minute, clock_second,
        output alarm_arm, alarm_load, alarm_h, alarm_m, alarm_s, stop_key, snooze_key,
        input  ring, ring_blink, snoozing, load_err,
        input  alarm_hour_q, alarm_minute_q, alarm_second_q
    );
    modport slave (
        input  sec_tick, clock_hour, clock_minute, clock_second,
        input  alarm_arm, alarm_load, alarm_h, alarm_m, alarm_s, stop_key, snooze_key,
        output ring, ring_blink, snoozing, load_err,
        output alarm_hour_q, alarm_minute_q, alarm_second_q
    );
endinterface

// File: rtl/alarm_scheduler.sv
// Alarm sequencer: stores the alarm time, triggers on the matching second tick, and
// sequences ringing / snooze / timeout. Every output comes straight from a flop.
module alarm_scheduler #(
    parameter int RING_TIMEOUT_S = 60,
    parameter int SNOOZE_S       = 300,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic               CLK_50,
    input  logic               reset_en,
    alarm_scheduler_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} state_e;

    localparam logic [11:0] RING_LAST  = 12'(RING_TIMEOUT_S - 1);
    localparam logic [11:0] SNOOZE_LEN = 12'(SNOOZE_S);
    localparam logic [1:0]  SNOOZE_MAX = 2'(MAX_SNOOZE);

    state_e      state_q, state_d;
    logic [11:0] ring_cnt_q, ring_cnt_d;
    logic [11:0] snooze_cnt_q, snooze_cnt_d;
    logic [1:0]  snooze_used_q, snooze_used_d;
    logic        ring_q, ring_d;
    logic        ring_blink_q, ring_blink_d;
    logic        snoozing_q, snoozing_d;
    logic        load_err_q, load_err_d;
    logic [5:0]  alarm_hour_q, alarm_hour_d;
    logic [5:0]  alarm_minute_q, alarm_minute_d;
    logic [5:0]  alarm_second_q, alarm_second_d;
    logic        load_ok;
    logic        time_match;

    assign load_ok    = (bus.alarm_h < 6'd24) && (bus.alarm_m < 6'd60) && (bus.alarm_s < 6'd60);
    assign time_match = (bus.clock_hour == alarm_hour_q) && (bus.clock_minute == alarm_minute_q) &&
                        (bus.clock_second == alarm_second_q);

    always_comb begin
        state_d        = state_q;
        ring_cnt_d     = ring_cnt_q;
        snooze_cnt_d   = snooze_cnt_q;
        snooze_used_d  = snooze_used_q;
        ring_blink_d   = ring_blink_q;
        load_err_d     = bus.alarm_load && !load_ok;
        alarm_hour_d   = alarm_hour_q;
        alarm_minute_d = alarm_minute_q;
        alarm_second_d = alarm_second_q;

        // Storing a valid load is independent of the arm switch; only state effects are prioritised.
        if (bus.alarm_load && load_ok) begin
            alarm_hour_d   = bus.alarm_h;
            alarm_minute_d = bus.alarm_m;
            alarm_second_d = bus.alarm_s;
        end

        if (!bus.alarm_arm) begin
            state_d       = IDLE;
            snooze_used_d = 2'd0;
        end else if (state_q == IDLE) begin
            state_d = ARMED;
        end else if (bus.alarm_load) begin
            // Any load claims the cycle; a valid one also cancels an active alarm event.
            if (load_ok && state_q != ARMED) begin
                state_d       = ARMED;
                snooze_used_d = 2'd0;
            end
        end else begin
            case (state_q)
                ARMED: begin
                    if (bus.sec_tick && time_match) begin
                        state_d      = RINGING;
                        ring_cnt_d   = 12'd0;
                        ring_blink_d = 1'b1;
                    end
                end
                RINGING: begin
                    if (bus.stop_key) begin
                        state_d       = ARMED;
                        snooze_used_d = 2'd0;
                    end else if (bus.snooze_key && snooze_used_q < SNOOZE_MAX) begin
                        state_d       = SNOOZE;
                        snooze_cnt_d  = SNOOZE_LEN;
                        snooze_used_d = snooze_used_q + 2'd1;
                    end else if (bus.sec_tick) begin
                        if (ring_cnt_q == RING_LAST) begin
                            state_d       = ARMED;
                            snooze_used_d = 2'd0;
                        end else begin
                            ring_cnt_d   = ring_cnt_q + 12'd1;
                            ring_blink_d = !ring_blink_q;
                        end
                    end
                end
                SNOOZE: begin
                    if (bus.stop_key) begin
                        state_d       = ARMED;
                        snooze_used_d = 2'd0;
                    end else if (bus.sec_tick) begin
                        snooze_cnt_d = snooze_cnt_q - 12'd1;
                        if (snooze_cnt_q == 12'd1) begin
                            state_d      = RINGING;
                            ring_cnt_d   = 12'd0;
                            ring_blink_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (state_d != RINGING) ring_blink_d = 1'b0;
        ring_d     = (state_d == RINGING);
        snoozing_d = (state_d == SNOOZE);
    end

    always_ff @(posedge CLK_50 or negedge reset_en) begin
        if (!reset_en) begin
            state_q        <= IDLE;
            ring_cnt_q     <= 12'd0;
            snooze_cnt_q   <= 12'd0;
            snooze_used_q  <= 2'd0;
            ring_q         <= 1'b0;
            ring_blink_q   <= 1'b0;
            snoozing_q     <= 1'b0;
            load_err_q     <= 1'b0;
            alarm_hour_q   <= 6'd0;
            alarm_minute_q <= 6'd0;
            alarm_second_q <= 6'd0;
        end else begin
            state_q        <= state_d;
            ring_cnt_q     <= ring_cnt_d;
            snooze_cnt_q   <= snooze_cnt_d;
            snooze_used_q  <= snooze_used_d;
            ring_q         <= ring_d;
            ring_blink_q   <= ring_blink_d;
            snoozing_q     <= snoozing_d;
            load_err_q     <= load_err_d;
            alarm_hour_q   <= alarm_hour_d;
            alarm_minute_q <= alarm_minute_d;
            alarm_second_q <= alarm_second_d;
        end
    end

    assign bus.ring           = ring_q;
    assign bus.ring_blink     = ring_blink_q;
    assign bus.snoozing       = snoozing_q;
    assign bus.load_err       = load_err_q;
    assign bus.alarm_hour_q   = alarm_hour_q;
    assign bus.alarm_minute_q = alarm_minute_q;
    assign bus.alarm_second_q = alarm_second_q;
endmodule

// File: tb/tb_alarm_scheduler.sv
// Bench for alarm_scheduler: load-vector table, directed ring/snooze sequences, then
// randomized traffic against a seconds-remaining reference model.
module tb_alarm_scheduler;
    localparam int RT = 60;
    localparam int SN = 5;
    localparam int MS = 3;
    localparam int M_IDLE = 0, M_ARMED = 1, M_RING = 2, M_SNZ = 3;
    localparam int DAY = 86400;
    localparam int T0730 = 7 * 3600 + 30 * 60;

    logic CLK_50 = 1'b0;
    logic reset_en = 1'b0;
    alarm_scheduler_if bus();

    alarm_scheduler #(.RING_TIMEOUT_S(RT), .SNOOZE_S(SN), .MAX_SNOOZE(MS)) dut (
        .CLK_50   (CLK_50),
        .reset_en (reset_en),
        .bus      (bus)
    );

    always #5 CLK_50 = ~CLK_50;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: ringing tracked as ticks left before timeout, snooze as ticks left to re-ring.
    int m_mode, m_ring_left, m_snz_left, m_used, m_h, m_m, m_s;
    bit m_blink, m_err;
    int tnow;

    typedef struct {
        int h, m, s;
        bit err;
        int eh, em, es;
    } load_vec_t;
    load_vec_t lv[8];

    function automatic void model_reset();
        m_mode = M_IDLE; m_ring_left = 0; m_snz_left = 0; m_used = 0;
        m_h = 0; m_m = 0; m_s = 0; m_blink = 0; m_err = 0;
    endfunction

    function automatic void model_step();
        bit ok, match;
        ok    = (bus.alarm_h < 24) && (bus.alarm_m < 60) && (bus.alarm_s < 60);
        match = bus.sec_tick && (bus.clock_hour == m_h) && (bus.clock_minute == m_m) &&
                (bus.clock_second == m_s);
        m_err = bus.alarm_load && !ok;
        if (!bus.alarm_arm) begin
            m_mode = M_IDLE; m_used = 0;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_ARMED;
        end else if (bus.alarm_load) begin
            if (ok && m_mode != M_ARMED) begin m_mode = M_ARMED; m_used = 0; end
        end else if (m_mode == M_ARMED) begin
            if (match) begin m_mode = M_RING; m_ring_left = RT; m_blink = 1; end
        end else if (bus.stop_key) begin
            m_mode = M_ARMED; m_used = 0;
        end else if (m_mode == M_RING && bus.snooze_key && m_used < MS) begin
            m_mode = M_SNZ; m_snz_left = SN; m_used++;
        end else if (bus.sec_tick) begin
            if (m_mode == M_RING) begin
                m_ring_left--; m_blink = !m_blink;
                if (m_ring_left == 0) begin m_mode = M_ARMED; m_used = 0; end
            end else begin
                m_snz_left--;
                if (m_snz_left == 0) begin m_mode = M_RING; m_ring_left = RT; m_blink = 1; end
            end
        end
        if (m_mode != M_RING) m_blink = 0;
        if (bus.alarm_load && ok) begin m_h = bus.alarm_h; m_m = bus.alarm_m; m_s = bus.alarm_s; end
    endfunction

    task automatic check_model(input string name);
        logic [27:0] act, exp_v;
        act   = {bus.ring, bus.ring_blink, bus.snoozing, bus.load_err,
                 bus.alarm_hour_q, bus.alarm_minute_q, bus.alarm_second_q};
        exp_v = {1'(m_mode == M_RING), m_blink, 1'(m_mode == M_SNZ), m_err, 6'(m_h), 6'(m_m), 6'(m_s)};
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (ring,blink,snz,err,h,m,s)", name, act, exp_v);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, act, exp_v);
        end
    endtask

    task automatic step(input string name);
        model_step();
        @(posedge CLK_50);
        #1;
        check_model(name);
    endtask

    task automatic set_time(input int t);
        int tt;
        tt = t % DAY;
        bus.clock_hour   = 6'(tt / 3600);
        bus.clock_minute = 6'((tt / 60) % 60);
        bus.clock_second = 6'(tt % 60);
    endtask

    task automatic tick_t(input int t);
        set_time(t);
        bus.sec_tick = 1'b1;
        step("tick");
        bus.sec_tick = 1'b0;
    endtask

    task automatic press(input bit stop, input bit snz);
        bus.stop_key = stop; bus.snooze_key = snz;
        step("key");
        bus.stop_key = 1'b0; bus.snooze_key = 1'b0;
    endtask

    task automatic load(input int h, input int m, input int s);
        bus.alarm_load = 1'b1;
        bus.alarm_h = 6'(h); bus.alarm_m = 6'(m); bus.alarm_s = 6'(s);
        step("load");
        bus.alarm_load = 1'b0;
    endtask

    initial begin
        bus.sec_tick = 0; bus.clock_hour = 0; bus.clock_minute = 0; bus.clock_second = 0;
        bus.alarm_arm = 0; bus.alarm_load = 0; bus.alarm_h = 0; bus.alarm_m = 0; bus.alarm_s = 0;
        bus.stop_key = 0; bus.snooze_key = 0;
        model_reset();
        #12;
        check_model("reset");
        @(negedge CLK_50);
        reset_en = 1'b1;
        step("post_reset");

        // Load validation table (disarmed).
        lv[0] = '{7, 30, 0, 1'b0, 7, 30, 0};
        lv[1] = '{24, 0, 0, 1'b1, 7, 30, 0};
        lv[2] = '{12, 60, 0, 1'b1, 7, 30, 0};
        lv[3] = '{23, 59, 60, 1'b1, 7, 30, 0};
        lv[4] = '{23, 59, 59, 1'b0, 23, 59, 59};
        lv[5] = '{63, 63, 63, 1'b1, 23, 59, 59};
        lv[6] = '{0, 0, 0, 1'b0, 0, 0, 0};
        lv[7] = '{7, 30, 0, 1'b0, 7, 30, 0};
        for (int i = 0; i < 8; i++) begin
            load(lv[i].h, lv[i].m, lv[i].s);
            chk("load_err", int'(bus.load_err), int'(lv[i].err));
            chk("stored", {bus.alarm_hour_q, bus.alarm_minute_q, bus.alarm_second_q},
                {6'(lv[i].eh), 6'(lv[i].em), 6'(lv[i].es)});
            step("load_idle");
        end

        // Arm and trigger at 07:30:00.
        bus.alarm_arm = 1'b1;
        step("arm");
        tick_t(T0730 - 1);
        chk("no_ring_early", int'(bus.ring), 0);
        tick_t(T0730);
        chk("ring_on_match", int'(bus.ring), 1);
        chk("blink_first", int'(bus.ring_blink), 1);

        // Unattended ringing lasts exactly RT ticks.
        for (int k = 1; k <= RT; k++) begin
            tick_t(T0730 + k);
            if (k == 1) chk("blink_toggle", int'(bus.ring_blink), 0);
            if (k == RT - 1) chk("ring_last", int'(bus.ring), 1);
            if (k == RT) chk("ring_timeout", int'(bus.ring), 0);
        end
        set_time(T0730);
        step("match_no_tick");
        chk("match_no_tick", int'(bus.ring), 0);
        tnow = T0730 + DAY;
        tick_t(tnow);
        chk("ring_next_day", int'(bus.ring), 1);

        // Three snoozes of SN ticks each, fourth ignored.
        for (int k = 0; k < 3; k++) begin tnow++; tick_t(tnow); end
        for (int n = 0; n < 3; n++) begin
            press(1'b0, 1'b1);
            chk("snoozing", int'(bus.snoozing), 1);
            for (int j = 1; j <= SN; j++) begin
                tnow++; tick_t(tnow);
                if (j == SN - 1) chk("snooze_quiet", int'(bus.ring), 0);
                if (j == SN) chk("snooze_rering", int'(bus.ring), 1);
            end
        end
        press(1'b0, 1'b1);
        chk("snooze4_ignored", {bus.ring, bus.snoozing}, 2'b10);
        press(1'b1, 1'b1);
        chk("stop_beats_snooze", {bus.ring, bus.snoozing}, 2'b00);

        // Tick and stop together: stop wins.
        tick_t(T0730);
        chk("retrigger", int'(bus.ring), 1);
        bus.stop_key = 1'b1;
        tick_t(T0730 + 1);
        bus.stop_key = 1'b0;
        chk("tick_stop", {bus.ring, bus.ring_blink}, 2'b00);

        // Valid load while ringing cancels the event.
        tick_t(T0730);
        load(8, 0, 0);
        chk("load_cancels", {bus.ring, bus.alarm_hour_q}, {1'b0, 6'd8});
        load(7, 30, 0);

        // Disarm during snooze.
        tick_t(T0730);
        press(1'b0, 1'b1);
        chk("snz_before_disarm", int'(bus.snoozing), 1);
        bus.alarm_arm = 1'b0;
        step("disarm");
        chk("disarm", {bus.ring, bus.snoozing}, 2'b00);
        bus.alarm_arm = 1'b1;
        step("rearm");

        // Midnight wrap.
        load(0, 0, 0);
        tick_t(DAY - 1);
        tick_t(DAY);
        chk("midnight", int'(bus.ring), 1);

        // Asynchronous reset mid-ringing.
        reset_en = 1'b0;
        #2;
        model_reset();
        check_model("reset_mid_ring");
        chk("reset_ring", int'(bus.ring), 0);
        @(negedge CLK_50);
        reset_en = 1'b1;
        step("post_reset2");

        // Randomized traffic with alarms loaded just ahead of the running clock.
        tnow = 3600;
        for (int i = 0; i < 4000; i++) begin
            bus.alarm_arm  = ($urandom_range(0, 199) != 0);
            bus.stop_key   = ($urandom_range(0, 59) == 0);
            bus.snooze_key = ($urandom_range(0, 14) == 0);
            bus.alarm_load = ($urandom_range(0, 79) == 0);
            if (bus.alarm_load) begin
                int ta;
                ta = (tnow + int'($urandom_range(1, 20))) % DAY;
                bus.alarm_h = 6'(ta / 3600);
                bus.alarm_m = 6'((ta / 60) % 60);
                bus.alarm_s = 6'(ta % 60);
                if ($urandom_range(0, 4) == 0) bus.alarm_m = 6'($urandom_range(60, 63));
            end
            bus.sec_tick = ($urandom_range(0, 2) == 0);
            if (bus.sec_tick) tnow++;
            set_time(tnow);
            step("rand");
        end
        bus.sec_tick = 0; bus.stop_key = 0; bus.snooze_key = 0; bus.alarm_load = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
